// File: rtl/qam_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : qam_rx_pkg
// Purpose  : State codes, data widths and counter sizing for the QAM16 RX
//            startup/lock sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package qam_rx_pkg;

   localparam int DF_W = 34;

   typedef enum logic [2:0] {
      ST_WAIT_PLL    = 3'd0,
      ST_RESET_DEMOD = 3'd1,
      ST_SETTLE      = 3'd2,
      ST_ACQUIRE     = 3'd3,
      ST_LOCKED      = 3'd4
   } state_t;

   function automatic int max_i(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // A counter that stops at n-1 needs clog2(n) bits, never fewer than one.
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_ff2.sv
`default_nettype none
// ============================================================================
// Module   : sync_ff2
// Purpose  : Two-flop synchronizer for a single asynchronous level input.
// Revision : 1.0 - initial release
// ============================================================================
module sync_ff2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule
`default_nettype wire

// File: rtl/qam_rx_seq.sv
`default_nettype none
// ============================================================================
// Module   : qam_rx_seq
// Purpose  : PLL-wait, demod reset/settle and carrier-lock supervision FSM.
// Revision : 1.0 - initial release
// ============================================================================
module qam_rx_seq
   import qam_rx_pkg::*;
#(
   parameter int              PLL_WAIT    = 1024,
   parameter int              RST_HOLD    = 16,
   parameter int              SETTLE      = 4096,
   parameter logic [DF_W-1:0] DF_THR      = 34'd4096,
   parameter int              LOCK_CNT    = 256,
   parameter int              UNLOCK_CNT  = 64,
   parameter int              ACQ_TIMEOUT = 65536
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   pll_locked,
   input  logic                   sample_en,
   input  logic signed [DF_W-1:0] df,
   output logic                   demod_rst,
   output logic                   out_en,
   output logic                   locked,
   output logic [2:0]             state,
   output logic [7:0]             relock_cnt
);

   localparam int PH_W  = cnt_w(max_i(max_i(PLL_WAIT, RST_HOLD), SETTLE));
   localparam int RUN_W = cnt_w(max_i(LOCK_CNT, UNLOCK_CNT));
   localparam int TO_W  = cnt_w(ACQ_TIMEOUT);

   localparam logic [PH_W-1:0]  PLL_LAST    = PH_W'(PLL_WAIT - 1);
   localparam logic [PH_W-1:0]  HOLD_LAST   = PH_W'(RST_HOLD - 1);
   localparam logic [PH_W-1:0]  SETTLE_LAST = PH_W'(SETTLE - 1);
   localparam logic [RUN_W-1:0] LOCK_LAST   = RUN_W'(LOCK_CNT - 1);
   localparam logic [RUN_W-1:0] UNLK_LAST   = RUN_W'(UNLOCK_CNT - 1);
   localparam logic [TO_W-1:0]  TO_LAST     = TO_W'(ACQ_TIMEOUT - 1);

   state_t            st, nxt;
   logic              pll_sync;
   logic [PH_W-1:0]   ph_cnt, ph_nxt;
   logic [RUN_W-1:0]  run_cnt, run_nxt;
   logic [TO_W-1:0]   to_cnt, to_nxt;
   logic              relock_inc;
   logic [DF_W-1:0]   df_abs;
   logic              good;

   sync_ff2 u_pll_sync (
      .clk (clk),
      .rst (rst),
      .d   (pll_locked),
      .q   (pll_sync)
   );

   // Two's-complement negate in 34 bits maps -2^33 onto 2^33 exactly.
   assign df_abs = df[DF_W-1] ? (~df + DF_W'(1)) : df;
   assign good   = (df_abs <= DF_THR);
   assign state  = st;

   always_comb begin
      nxt        = st;
      ph_nxt     = ph_cnt;
      run_nxt    = run_cnt;
      to_nxt     = to_cnt;
      relock_inc = 1'b0;
      case (st)
         ST_WAIT_PLL: begin
            if (!pll_sync)                ph_nxt = '0;
            else if (ph_cnt == PLL_LAST)  nxt    = ST_RESET_DEMOD;
            else                          ph_nxt = ph_cnt + PH_W'(1);
         end
         ST_RESET_DEMOD: begin
            if (ph_cnt == HOLD_LAST)      nxt    = ST_SETTLE;
            else                          ph_nxt = ph_cnt + PH_W'(1);
         end
         ST_SETTLE: begin
            if (sample_en) begin
               if (ph_cnt == SETTLE_LAST) nxt    = ST_ACQUIRE;
               else                       ph_nxt = ph_cnt + PH_W'(1);
            end
         end
         ST_ACQUIRE: begin
            if (sample_en) begin
               run_nxt = good ? run_cnt + RUN_W'(1) : '0;
               to_nxt  = to_cnt + TO_W'(1);
               // Lock takes precedence when both limits land on one strobe.
               if (good && run_cnt == LOCK_LAST) begin
                  nxt = ST_LOCKED;
               end else if (to_cnt == TO_LAST) begin
                  nxt        = ST_RESET_DEMOD;
                  relock_inc = 1'b1;
               end
            end
         end
         ST_LOCKED: begin
            if (sample_en) begin
               if (good) begin
                  run_nxt = '0;
               end else if (run_cnt == UNLK_LAST) begin
                  nxt        = ST_RESET_DEMOD;
                  relock_inc = 1'b1;
               end else begin
                  run_nxt = run_cnt + RUN_W'(1);
               end
            end
         end
         default: nxt = ST_WAIT_PLL;
      endcase
      if (st != ST_WAIT_PLL && !pll_sync) begin
         nxt        = ST_WAIT_PLL;
         relock_inc = 1'b0;
      end
      if (nxt != st) begin
         ph_nxt  = '0;
         run_nxt = '0;
         to_nxt  = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st         <= ST_WAIT_PLL;
         ph_cnt     <= '0;
         run_cnt    <= '0;
         to_cnt     <= '0;
         demod_rst  <= 1'b1;
         out_en     <= 1'b0;
         locked     <= 1'b0;
         relock_cnt <= 8'd0;
      end else begin
         st        <= nxt;
         ph_cnt    <= ph_nxt;
         run_cnt   <= run_nxt;
         to_cnt    <= to_nxt;
         demod_rst <= (nxt == ST_WAIT_PLL) || (nxt == ST_RESET_DEMOD);
         out_en    <= (nxt == ST_LOCKED);
         locked    <= (nxt == ST_LOCKED);
         if (relock_inc && relock_cnt != 8'hFF) relock_cnt <= relock_cnt + 8'd1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_qam_rx_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_qam_rx_seq
// Purpose  : Directed self-checking bench for the QAM16 RX lock sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qam_rx_seq;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               pll_locked = 1'b0;
   logic               sample_en = 1'b0;
   logic signed [33:0] df = '0;
   logic               demod_rst, out_en, locked;
   logic [2:0]         state;
   logic [7:0]         relock_cnt;

   int total  = 0;
   int passed = 0;

   typedef struct {
      logic [33:0] df;
      logic [2:0]  st;
      logic        lk;
      logic        oe;
      logic        dr;
      logic [7:0]  rc;
   } vec_t;

   vec_t tbl[16];

   qam_rx_seq #(
      .PLL_WAIT    (8),
      .RST_HOLD    (4),
      .SETTLE      (10),
      .DF_THR      (34'd100),
      .LOCK_CNT    (5),
      .UNLOCK_CNT  (3),
      .ACQ_TIMEOUT (20)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .pll_locked (pll_locked),
      .sample_en  (sample_en),
      .df         (df),
      .demod_rst  (demod_rst),
      .out_en     (out_en),
      .locked     (locked),
      .state      (state),
      .relock_cnt (relock_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe_only(input logic [33:0] v);
      sample_en = 1'b1;
      df        = v;
      tick();
      sample_en = 1'b0;
   endtask

   task automatic strobe(input logic [33:0] v);
      strobe_only(v);
      tick();
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      pll_locked = 1'b0;
      sample_en  = 1'b0;
      df         = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Reset, lock the PLL, pass WAIT_PLL/RESET_DEMOD and 10 settle strobes.
   task automatic reach_acquire();
      do_reset();
      pll_locked = 1'b1;
      repeat (14) tick();
      repeat (10) strobe(34'd0);
      chk("reach_acquire_state", state, 3);
   endtask

   initial begin
      tbl[0]  = '{34'd100,          3'd3, 1'b0, 1'b0, 1'b0, 8'd0};
      tbl[1]  = '{-34'sd100,        3'd3, 1'b0, 1'b0, 1'b0, 8'd0};
      tbl[2]  = '{34'd101,          3'd3, 1'b0, 1'b0, 1'b0, 8'd0};
      tbl[3]  = '{34'h2_0000_0000,  3'd3, 1'b0, 1'b0, 1'b0, 8'd0};
      tbl[4]  = '{34'h1_FFFF_FFFF,  3'd3, 1'b0, 1'b0, 1'b0, 8'd0};
      tbl[5]  = '{34'd0,            3'd3, 1'b0, 1'b0, 1'b0, 8'd0};
      tbl[6]  = '{34'd50,           3'd3, 1'b0, 1'b0, 1'b0, 8'd0};
      tbl[7]  = '{-34'sd1,          3'd3, 1'b0, 1'b0, 1'b0, 8'd0};
      tbl[8]  = '{34'd99,           3'd3, 1'b0, 1'b0, 1'b0, 8'd0};
      tbl[9]  = '{-34'sd99,         3'd4, 1'b1, 1'b1, 1'b0, 8'd0};
      tbl[10] = '{34'd101,          3'd4, 1'b1, 1'b1, 1'b0, 8'd0};
      tbl[11] = '{-34'sd101,        3'd4, 1'b1, 1'b1, 1'b0, 8'd0};
      tbl[12] = '{-34'sd100,        3'd4, 1'b1, 1'b1, 1'b0, 8'd0};
      tbl[13] = '{34'd101,          3'd4, 1'b1, 1'b1, 1'b0, 8'd0};
      tbl[14] = '{-34'sd101,        3'd4, 1'b1, 1'b1, 1'b0, 8'd0};
      tbl[15] = '{34'd101,          3'd1, 1'b0, 1'b0, 1'b1, 8'd1};

      // Cold start
      do_reset();
      chk("reset_vals", {state, locked, out_en, demod_rst, relock_cnt}, {3'd0, 1'b0, 1'b0, 1'b1, 8'd0});
      pll_locked = 1'b1;
      repeat (9) tick();
      chk("wait_pll_e9", {state, demod_rst}, {3'd0, 1'b1});
      tick();
      chk("reset_demod_e10", {state, demod_rst}, {3'd1, 1'b1});
      repeat (3) tick();
      chk("reset_demod_e13", {state, demod_rst}, {3'd1, 1'b1});
      tick();
      chk("settle_e14", {state, demod_rst}, {3'd2, 1'b0});
      repeat (9) strobe(34'd50);
      chk("settle_9_strobes", state, 2);
      strobe_only(34'd50);
      chk("acquire_after_10", state, 3);
      tick();
      repeat (4) strobe(34'd50);
      chk("four_good_not_locked", {state, locked}, {3'd3, 1'b0});
      strobe_only(34'd50);
      chk("cold_lock", {state, locked, out_en, relock_cnt}, {3'd4, 1'b1, 1'b1, 8'd0});
      tick();

      // Boundary |df|, good-run reset, lock, loss of lock
      reach_acquire();
      for (int i = 0; i < 16; i++) begin
         strobe_only(tbl[i].df);
         chk($sformatf("vec%0d", i), {state, locked, out_en, demod_rst, relock_cnt},
             {tbl[i].st, tbl[i].lk, tbl[i].oe, tbl[i].dr, tbl[i].rc});
         tick();
      end

      // Async reset mid-SETTLE
      repeat (3) tick();
      chk("settle_after_relock", {state, demod_rst, relock_cnt}, {3'd2, 1'b0, 8'd1});
      repeat (2) strobe(34'd0);
      #2 rst = 1'b1;
      #1;
      chk("async_rst", {state, locked, out_en, demod_rst, relock_cnt}, {3'd0, 1'b0, 1'b0, 1'b1, 8'd0});

      // Acquisition timeout and relock saturation
      reach_acquire();
      repeat (19) strobe(34'd1000);
      chk("timeout_19", state, 3);
      strobe_only(34'd1000);
      chk("timeout_20", {state, demod_rst, relock_cnt}, {3'd1, 1'b1, 8'd1});
      tick();
      repeat (300 * 32) strobe(34'd1000);
      chk("relock_saturate", relock_cnt, 8'd255);

      // Lock and timeout on the same strobe
      reach_acquire();
      repeat (15) strobe(34'd1000);
      repeat (4) strobe(34'd50);
      chk("both_19", state, 3);
      strobe_only(34'd50);
      chk("both_20", {state, relock_cnt}, {3'd4, 8'd0});
      tick();

      // PLL drop from LOCKED
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      tick();
      chk("pll_drop_e2", {state, out_en}, {3'd4, 1'b1});
      tick();
      chk("pll_drop_e3", {state, out_en, demod_rst, locked, relock_cnt}, {3'd0, 1'b0, 1'b1, 1'b0, 8'd0});

      // Sub-cycle glitch between edges is never sampled
      reach_acquire();
      repeat (5) strobe(34'd50);
      chk("glitch_pre_lock", state, 4);
      #2 pll_locked = 1'b0;
      #2 pll_locked = 1'b1;
      repeat (5) tick();
      chk("glitch_ignored", {state, locked}, {3'd4, 1'b1});

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/qam_rx_seq.md
# qam_rx_seq

Startup and lock-supervision sequencer for the QAM16 receive path. It waits for the system PLL to lock, then holds the carrier-recovery demodulator in reset, lets it settle, and declares carrier lock from the demodulator's frequency-error word. It gates the I/Q output registers and re-runs acquisition on timeout or loss of lock. It sits in the board top level, beside the PLL and the demodulator, and runs in the `sys_clk` domain.

## Interface
Parameters:
- `PLL_WAIT`, 1024: consecutive synchronized `pll_locked` cycles required before leaving WAIT_PLL.
- `RST_HOLD`, 16: clk cycles that `demod_rst` is held in RESET_DEMOD.
- `SETTLE`, 4096: `sample_en` strobes ignored after demod reset release.
- `DF_THR`, 34'd4096: lock threshold on |df|; in-lock means |df| <= DF_THR.
- `LOCK_CNT`, 256: consecutive in-lock samples needed to declare lock.
- `UNLOCK_CNT`, 64: consecutive out-of-lock samples needed to drop lock.
- `ACQ_TIMEOUT`, 65536: samples allowed in ACQUIRE before the demod is reset again.

Ports:
- `clk` in 1: sys_clk.
- `rst` in 1: asynchronous, active-high reset.
- `pll_locked` in 1: raw PLL lock flag, asynchronous.
- `sample_en` in 1: one-cycle strobe marking a valid `df` sample.
- `df` in 34 signed: demodulator frequency error.
- `demod_rst` out 1: active-high reset to the demodulator.
- `out_en` out 1: enables the I/Q output registers.
- `locked` out 1: carrier lock indicator, drives an LED.
- `state` out 3: current state code.
- `relock_cnt` out 8: number of re-acquisitions, saturating.

## Operation
- `pll_locked` passes through a 2-flop synchronizer before use.
- States and codes: WAIT_PLL=0, RESET_DEMOD=1, SETTLE=2, ACQUIRE=3, LOCKED=4. Codes 5–7 are illegal and go to WAIT_PLL on the next clk.
- WAIT_PLL:
  - `demod_rst`=1.
  - The counter counts up while the synced lock is 1 and clears to 0 when it is 0.
  - Reaching `PLL_WAIT` moves to RESET_DEMOD.
- RESET_DEMOD: `demod_rst`=1 for `RST_HOLD` cycles, then SETTLE.
- SETTLE: `demod_rst`=0. Count `sample_en` strobes; after `SETTLE` strobes, go to ACQUIRE.
- ACQUIRE:
  - On each strobe, `good`=(|df| <= DF_THR).
  - The good-run counter increments on `good` and clears otherwise; reaching `LOCK_CNT` moves to LOCKED.
  - The timeout counter increments on every strobe; reaching `ACQ_TIMEOUT` moves to RESET_DEMOD and increments `relock_cnt`.
  - If both limits are reached on the same strobe, LOCKED wins.
- LOCKED:
  - `locked`=1 and `out_en`=1.
  - The bad-run counter increments on !`good` and clears on `good`.
  - Reaching `UNLOCK_CNT` moves to RESET_DEMOD and increments `relock_cnt`.
- Synced lock low in any state other than WAIT_PLL moves to WAIT_PLL. This has priority over every other transition and does not increment `relock_cnt`.
- |df| arithmetic:
  - Computed as a 34-bit unsigned value: (df<0) ? -df : df.
  - df = -2^33 gives 2^33. This is exact, no saturation is needed.
- Every counter clears on state entry.
- `relock_cnt` saturates at 255 and clears only on `rst`.

## Timing
- All outputs are registered and reflect the current state; no output is combinational from inputs.
- Reset values:
  - `demod_rst`=1, `out_en`=0, `locked`=0.
  - `state`=0, `relock_cnt`=0.
  - Synchronizer flops=0, all counters=0.
- `pll_locked` falling reaches WAIT_PLL, with `demod_rst`=1 and `out_en`=0, on the 3rd clk edge: 2 synchronizer edges plus 1 state edge.
- A `sample_en` strobe is evaluated on the same edge it is high. A transition it causes is visible on the following cycle.
- `df` is sampled only when `sample_en`=1. Non-strobe cycles do not affect any counter except those in WAIT_PLL and RESET_DEMOD.
- `rst` asserted mid-operation forces the reset values immediately, asynchronously. Deassertion resumes from WAIT_PLL.

## Structure
- Package `qam_rx_pkg`:
  - State encoding constants.
  - DF_W=34.
  - Counter width helper: clog2-based width per parameter.
- Sub-module `sync_ff2`: 2-flop synchronizer, reusable for `ADA_OR` and switch inputs elsewhere.
- The FSM, counters and |df| compare stay in `qam_rx_seq`.

## Test plan
Benches use small parameters: PLL_WAIT=8, RST_HOLD=4, SETTLE=10, LOCK_CNT=5, UNLOCK_CNT=3, ACQ_TIMEOUT=20, DF_THR=100.
- Cold start: `rst` pulse, then `pll_locked`=1 with `sample_en` every 2nd cycle and df=50.
  - `demod_rst` stays 1 through WAIT_PLL (8 cycles after the synchronizer) plus RESET_DEMOD (4 cycles).
  - `locked` rises after 10 settle strobes plus 5 good strobes; `relock_cnt`=0.
- Acquisition timeout: df=1000 held.
  - After 20 strobes in ACQUIRE, `state`=1 and `demod_rst`=1; `relock_cnt`=1.
  - Repeating 300 times, `relock_cnt` holds at 255.
- Loss of lock and boundary: from LOCKED, drive df=101, -101, 101.
  - `locked` drops after the 3rd strobe.
  - A sequence of 2 bad, 1 good (df=-100), 2 bad keeps `locked`=1.
- Both limits on the same strobe: good-run reaches 5 on the same strobe the timeout reaches 20 → `state`=4 and `relock_cnt` unchanged.
- PLL drop: in LOCKED, pulse `pll_locked`=0.
  - `state`=0, `out_en`=0, `demod_rst`=1 on the 3rd clk edge; `relock_cnt` unchanged.
  - A glitch shorter than one clk, not sampled, has no effect.
- Extreme df: df=-2^33 in ACQUIRE is counted as bad. Async `rst` mid-SETTLE immediately restores all reset values.
